// File: rtl/fifo_uart_tx_reader_if.sv
// FIFO read port as seen by the UART TX reader: empty flag, registered read data, read strobe.
interface fifo_uart_tx_reader_if #(
  parameter int unsigned data_len = 8
) ();
  logic                fifo_empty;
  logic [data_len-1:0] fifo_data;
  logic                fifo_rd_en;

  modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx_reader.sv
// Drains FIFO words one at a time onto an 8N1, LSB-first UART TX line with busy/done/frame counter.
// Define PARITY_EN to insert an even-parity bit between the data field and the stop bit.
module fifo_uart_tx_reader #(
  parameter int unsigned data_len     = 8,
  parameter int unsigned clks_per_bit = 10416,
  parameter int unsigned cnt_len      = 8
) (
  input  logic                  clk_fpga,
  input  logic                  nreset,
  fifo_uart_tx_reader_if.master fifo,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [cnt_len-1:0]    frame_count
);
  localparam int unsigned BAUD_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int unsigned BIT_W  = (data_len > 1) ? $clog2(data_len) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clks_per_bit - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(data_len - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
`ifdef PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
  logic parity_q, parity_d;
`endif

  logic [2:0]          state_q, state_d;
  logic                rd_en_q, rd_en_d;
  logic [data_len-1:0] shift_q, shift_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [cnt_len-1:0]  count_q, count_d;

  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
`ifdef PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      // IDLE spans the evaluation cycle and the read-strobe cycle; data lands in FETCH.
      IDLE: begin
        if (rd_en_q) state_d = FETCH;
        else if (!fifo.fifo_empty) rd_en_d = 1'b1;
      end
      FETCH: begin
        shift_d = fifo.fifo_data;
        baud_d  = '0;
        bit_d   = '0;
`ifdef PARITY_EN
        parity_d = ^fifo.fifo_data;
`endif
        state_d = START;
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (baud_d == BAUD_LAST);
    count_d = done_d ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk_fpga or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      rd_en_q  <= 1'b0;
      shift_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_en_q  <= rd_en_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
`ifdef PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo.fifo_rd_en = rd_en_q;
  assign tx              = tx_q;
  assign tx_busy         = busy_q;
  assign tx_done         = done_q;
  assign frame_count     = count_q;
endmodule

// File: tb/tb_fifo_uart_tx_reader.sv
// Scoreboard bench for fifo_uart_tx_reader: stimulus queues expected frames, a monitor decodes tx on each tx_done.
module tb_fifo_uart_tx_reader;
  localparam int unsigned DL  = 8;
  localparam int unsigned CPB = 4;
  localparam int unsigned CL  = 8;
`ifdef PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

  logic          clk;
  logic          nreset;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;
  logic [CL-1:0] frame_count;

  fifo_uart_tx_reader_if #(.data_len(DL)) fifo_if ();

  fifo_uart_tx_reader #(
    .data_len(DL),
    .clks_per_bit(CPB),
    .cnt_len(CL)
  ) dut (
    .clk_fpga(clk),
    .nreset(nreset),
    .fifo(fifo_if),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned rd_count = 0;
  bit          gap_chk  = 0;
  logic        rd_prev  = 1'b0;

  logic [DL-1:0] fifo_mem[$];
  logic [10:0]   exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp_v);
    end
  endtask

  // FIFO model: registered read data, empty flag refreshed away from the active edge.
  always @(posedge clk)
    if (fifo_if.fifo_rd_en && fifo_mem.size() > 0)
      fifo_if.fifo_data <= fifo_mem.pop_front();

  always @(negedge clk)
    fifo_if.fifo_empty <= (fifo_mem.size() == 0);

  always @(negedge clk) begin
    if (nreset && fifo_if.fifo_rd_en) begin
      rd_count++;
      chk("rd_en_legal", {rd_prev, fifo_if.fifo_empty}, 2'b00);
    end
    rd_prev <= fifo_if.fifo_rd_en;
  end

  initial begin : monitor
    int unsigned   cyc, idx, done_cyc;
    bit            in_frame, done_seen;
    logic [63:0]   samples, exp_s;
    logic [10:0]   ef;
    logic [CL-1:0] model_cnt;
    cyc = 0; idx = 0; done_cyc = 0; in_frame = 0; done_seen = 0;
    samples = '0; model_cnt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nreset) begin
        in_frame  = 0;
        done_seen = 0;
        model_cnt = '0;
        idx       = 0;
      end else begin
        if (!in_frame && tx == 1'b0) begin
          in_frame = 1;
          idx      = 0;
          samples  = '0;
          if (gap_chk && done_seen) chk("frame_gap", 64'(cyc - done_cyc), 64'd4);
        end
        if (in_frame && idx < 64) begin
          samples[idx] = tx;
          idx++;
        end
        if (tx_done) begin
          model_cnt++;
          chk("frame_count_at_done", 64'(frame_count), 64'(model_cnt));
          chk("busy_at_done", 64'(tx_busy), 64'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(exp_q.size()), 64'd1);
          end else begin
            ef    = exp_q.pop_front();
            exp_s = '0;
            for (int c = 0; c < int'(FRAME_CYC); c++) exp_s[c] = ef[c / CPB];
            chk("frame_len", 64'(idx), 64'(FRAME_CYC));
            chk("frame_bits", samples, exp_s);
          end
          in_frame  = 0;
          done_seen = 1;
          done_cyc  = cyc;
        end
      end
    end
  end

  // fr is the 10-bit 8N1 frame in time order (bit 0 = start); par is the even-parity bit.
  task automatic push(input logic [DL-1:0] w, input logic [9:0] fr, input logic par);
    logic [10:0] f;
`ifdef PARITY_EN
    f = {fr[9], par, fr[8:0]};
`else
    f = {1'b0, fr};
`endif
    fifo_mem.push_back(w);
    exp_q.push_back(f);
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || fifo_mem.size() != 0 || tx_busy) && n < budget);
    chk(name, 64'(exp_q.size() == 0 && fifo_mem.size() == 0 && !tx_busy), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int unsigned   rd_base, bad;
    bit            seen;
    logic [DL-1:0] w;

    nreset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", {52'd0, tx, fifo_if.fifo_rd_en, tx_busy, tx_done, frame_count},
        {52'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    nreset = 1'b1;

    // Empty FIFO: line idles and nothing is read.
    rd_base = rd_count;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || frame_count !== '0 ||
          fifo_if.fifo_rd_en !== 1'b0) bad++;
    end
    chk("idle_100_cycles", 64'(bad), 64'd0);
    chk("idle_no_reads", 64'(rd_count - rd_base), 64'd0);

    // Single word.
    do_reset();
    rd_base = rd_count;
    push(8'hA5, 10'b1_10100101_0, 1'b0);
    wait_drain("drain_single", 300);
    chk("single_frame_count", 64'(frame_count), 64'd1);
    chk("single_reads", 64'(rd_count - rd_base), 64'd1);
    chk("single_tx_idle", 64'(tx), 64'd1);

    // Three back-to-back words.
    do_reset();
    gap_chk = 1;
    rd_base = rd_count;
    push(8'h00, 10'b1_00000000_0, 1'b0);
    push(8'hFF, 10'b1_11111111_0, 1'b0);
    push(8'h3C, 10'b1_00111100_0, 1'b0);
    wait_drain("drain_three", 600);
    gap_chk = 0;
    chk("three_frame_count", 64'(frame_count), 64'd3);
    chk("three_reads", 64'(rd_count - rd_base), 64'd3);

    // Reset during the 5th data bit of 8'h81 (bit value 0).
    do_reset();
    rd_base = rd_count;
    fifo_mem.push_back(8'h81);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (fifo_if.fifo_rd_en) seen = 1;
    end
    chk("abort_rd_seen", 64'(seen), 64'd1);
    repeat (22) @(negedge clk);
    chk("abort_bit4_low", 64'(tx), 64'd0);
    nreset = 1'b0;
    #1;
    chk("abort_tx_high", 64'(tx), 64'd1);
    chk("abort_no_done", 64'(tx_done), 64'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    chk("abort_stays_idle", 64'(bad), 64'd0);
    chk("abort_frame_count", 64'(frame_count), 64'd0);
    chk("abort_reads", 64'(rd_count - rd_base), 64'd1);

`ifdef PARITY_EN
    // Even parity: 8'h07 has three ones, 8'h03 has two.
    do_reset();
    push(8'h07, 10'b1_00000111_0, 1'b1);
    push(8'h03, 10'b1_00000011_0, 1'b0);
    wait_drain("drain_parity", 400);
    chk("parity_frame_count", 64'(frame_count), 64'd2);
`endif

    // 256 frames wrap the 8-bit counter.
    do_reset();
    gap_chk = 1;
    rd_base = rd_count;
    for (int unsigned i = 0; i < 256; i++) begin
      w = DL'(i);
      push(w, {1'b1, w, 1'b0}, ^w);
    end
    wait_drain("drain_256", 20000);
    gap_chk = 0;
    chk("wrap_frame_count", 64'(frame_count), 64'd0);
    chk("wrap_reads", 64'(rd_count - rd_base), 64'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
